// File: rtl/ahb_uart_fifo.sv
// AHB-Lite UART with TX/RX byte FIFOs, programmable baud divisor, parity/stop
// options and sticky error flags, driving one level interrupt.

// Byte FIFO with a circular buffer, read/write pointers and an occupancy count.
// A push while full is dropped and a pop while empty is ignored.
module UartFifo #(
   parameter int DEPTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic [7:0]              pushData,
   input  logic                    pop,
   output logic [7:0]              head,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rdPtr;
   logic [AW-1:0] wrPtr;
   logic          doPush;
   logic          doPop;

   assign doPush = push && (count != (AW+1)'(DEPTH));
   assign doPop  = pop && (count != '0);
   assign head   = mem[rdPtr];

   // Storage has no reset; clearing the count and pointers is what empties the FIFO.
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
   // legal push and pop leaves the count unchanged.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   end
endmodule

module ahb_uart_fifo #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] DIV_RESET  = 16'd26
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic        HREADY,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   input  logic        serialRx,
   output logic        serialTx,
   output logic        uart_IRQ
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2} txState_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;

   logic [2:0]  dataAddr;
   logic        dataWrite, dataValid, wrStrobe, rdStrobe, statusWrite;
   logic [7:0]  contrl, txLast, status;
   logic [15:0] baudDiv, prescale;
   logic        tick;
   logic        rxOverrun, parityError, frameError, txOverflow;
   logic [CW-1:0] txCount, rxCount;
   logic [7:0]  txHead, rxHead;
   logic        txPush, txPop, rxPop, txFull, txEmpty, rxFull, rxEmpty;
   txState_t    txState;
   logic [7:0]  txShift;
   logic [3:0]  txTicks;
   logic [2:0]  txBit;
   logic        txParityBit, txUseParity, txTwoStop;
   rxState_t    rxState;
   logic        rxMeta, rxSync;
   logic [7:0]  rxShift, rxPushByte;
   logic [3:0]  rxTicks;
   logic [2:0]  rxBit;
   logic        rxUseParity, rxOddParity, rxBadParity;
   logic        rxPushPulse, rxPushBadParity, rxFrameSet;
   logic        unusedBits;

   assign HREADYOUT   = 1'b1;
   assign unusedBits  = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:16]};
   assign wrStrobe    = dataValid & dataWrite;
   assign rdStrobe    = dataValid & ~dataWrite;
   assign statusWrite = wrStrobe && (dataAddr == 3'd2);
   assign txPush      = wrStrobe && (dataAddr == 3'd1);
   assign txFull      = (txCount == FULL_COUNT);
   assign txEmpty     = (txCount == '0);
   assign rxFull      = (rxCount == FULL_COUNT);
   assign rxEmpty     = (rxCount == '0);
   assign rxPop       = rdStrobe && (dataAddr == 3'd0) && !rxEmpty;
   assign txPop       = (txState == TX_IDLE) && !txEmpty;
   assign tick        = (prescale == baudDiv);
   assign status      = {txOverflow, frameError, parityError, rxOverrun, !rxEmpty, rxFull, txEmpty, txFull};

   UartFifo #(.DEPTH(FIFO_DEPTH)) txFifo (
      .clock(HCLK), .reset(HRESET), .push(txPush), .pushData(HWDATA[7:0]),
      .pop(txPop), .head(txHead), .count(txCount)
   );

   UartFifo #(.DEPTH(FIFO_DEPTH)) rxFifo (
      .clock(HCLK), .reset(HRESET), .push(rxPushPulse), .pushData(rxPushByte),
      .pop(rxPop), .head(rxHead), .count(rxCount)
   );

   // Address phase capture: the data phase that follows always completes in one
   // cycle, so the registered address and write flag drive everything after it.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dataValid <= 1'b0;
         dataAddr  <= '0;
         dataWrite <= 1'b0;
      end else if (HREADY) begin
         dataValid <= HSEL & HTRANS[1];
         dataAddr  <= HADDR[4:2];
         dataWrite <= HWRITE;
      end
   end

   // Read mux is combinational from the registered address; an empty RX FIFO reads 0.
   always_comb begin
      HRDATA = '0;
      if (rdStrobe) begin
         case (dataAddr)
            3'd0: HRDATA = rxEmpty ? 32'd0 : {24'd0, rxHead};
            3'd1: HRDATA = {24'd0, txLast};
            3'd2: HRDATA = {24'd0, status};
            3'd3: HRDATA = {24'd0, contrl};
            3'd4: HRDATA = {16'd0, baudDiv};
            3'd5: HRDATA = {8'd0, 8'(rxCount), 8'd0, 8'(txCount)};
            default: HRDATA = '0;
         endcase
      end
   end

   // Control registers, sticky error flags and the interrupt. A new error event
   // in the same cycle as its write-one-to-clear wins, so no event is lost.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         contrl      <= '0;
         baudDiv     <= DIV_RESET;
         txLast      <= '0;
         rxOverrun   <= 1'b0;
         parityError <= 1'b0;
         frameError  <= 1'b0;
         txOverflow  <= 1'b0;
         uart_IRQ    <= 1'b0;
      end else begin
         if (wrStrobe) begin
            case (dataAddr)
               3'd1: txLast  <= HWDATA[7:0];
               3'd3: contrl  <= HWDATA[7:0];
               3'd4: baudDiv <= HWDATA[15:0];
               default: ;
            endcase
         end
         rxOverrun   <= (rxOverrun & ~(statusWrite & HWDATA[4])) | (rxPushPulse & rxFull);
         parityError <= (parityError & ~(statusWrite & HWDATA[5])) | (rxPushPulse & rxPushBadParity);
         frameError  <= (frameError & ~(statusWrite & HWDATA[6])) | rxFrameSet;
         txOverflow  <= (txOverflow & ~(statusWrite & HWDATA[7])) | (txPush & txFull);
         uart_IRQ    <= (|(status[3:0] & contrl[3:0])) | (contrl[4] & (|status[7:4]));
      end
   end

   // Baud prescaler producing one 16x oversample tick every baudDiv+1 cycles.
   // Rewriting the divisor restarts the count so the new rate applies at once.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         prescale <= '0;
      end else if ((wrStrobe && (dataAddr == 3'd4)) || tick) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + 16'd1;
      end
   end

   // Transmitter: the frame format is frozen when a byte leaves the FIFO, and
   // every bit holds for 16 ticks before the next one is driven onto the line.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         txState     <= TX_IDLE;
         serialTx    <= 1'b1;
         txShift     <= '0;
         txTicks     <= '0;
         txBit       <= '0;
         txParityBit <= 1'b0;
         txUseParity <= 1'b0;
         txTwoStop   <= 1'b0;
      end else if (txState == TX_IDLE) begin
         if (!txEmpty) begin
            txShift     <= txHead;
            txParityBit <= (^txHead) ^ contrl[6];
            txUseParity <= contrl[6] ^ contrl[5];
            txTwoStop   <= contrl[7];
            txTicks     <= '0;
            serialTx    <= 1'b0;
            txState     <= TX_START;
         end
      end else if (tick) begin
         txTicks <= txTicks + 4'd1;
         if (txTicks == 4'd15) begin
            case (txState)
               TX_START: begin
                  txState  <= TX_DATA;
                  txBit    <= '0;
                  serialTx <= txShift[0];
               end
               TX_DATA: begin
                  if (txBit == 3'd7) begin
                     txState  <= txUseParity ? TX_PARITY : TX_STOP1;
                     serialTx <= txUseParity ? txParityBit : 1'b1;
                  end else begin
                     txBit    <= txBit + 3'd1;
                     txShift  <= {1'b0, txShift[7:1]};
                     serialTx <= txShift[1];
                  end
               end
               TX_PARITY: begin
                  txState  <= TX_STOP1;
                  serialTx <= 1'b1;
               end
               TX_STOP1: begin
                  txState  <= txTwoStop ? TX_STOP2 : TX_IDLE;
                  serialTx <= 1'b1;
               end
               default: begin
                  txState  <= TX_IDLE;
                  serialTx <= 1'b1;
               end
            endcase
         end
      end
   end

   // Receiver: a two-flop synchroniser feeds a state machine that confirms the
   // start bit half a bit in, then samples each later bit 16 ticks apart so
   // every sample lands mid-bit. The completed byte is pushed one cycle later.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         rxMeta          <= 1'b1;
         rxSync          <= 1'b1;
         rxState         <= RX_IDLE;
         rxShift         <= '0;
         rxTicks         <= '0;
         rxBit           <= '0;
         rxUseParity     <= 1'b0;
         rxOddParity     <= 1'b0;
         rxBadParity     <= 1'b0;
         rxPushPulse     <= 1'b0;
         rxPushByte      <= '0;
         rxPushBadParity <= 1'b0;
         rxFrameSet      <= 1'b0;
      end else begin
         rxMeta      <= serialRx;
         rxSync      <= rxMeta;
         rxPushPulse <= 1'b0;
         rxFrameSet  <= 1'b0;
         if (rxState == RX_IDLE) begin
            if (!rxSync) begin
               rxState     <= RX_START;
               rxTicks     <= '0;
               rxBadParity <= 1'b0;
               rxUseParity <= contrl[6] ^ contrl[5];
               rxOddParity <= contrl[6];
            end
         end else if (tick) begin
            if (rxState == RX_START) begin
               if (rxTicks == 4'd7) begin
                  rxState <= rxSync ? RX_IDLE : RX_DATA;
                  rxTicks <= '0;
                  rxBit   <= '0;
               end else begin
                  rxTicks <= rxTicks + 4'd1;
               end
            end else if (rxTicks != 4'd15) begin
               rxTicks <= rxTicks + 4'd1;
            end else begin
               rxTicks <= '0;
               case (rxState)
                  RX_DATA: begin
                     rxShift <= {rxSync, rxShift[7:1]};
                     rxBit   <= rxBit + 3'd1;
                     if (rxBit == 3'd7) begin
                        rxState <= rxUseParity ? RX_PARITY : RX_STOP;
                     end
                  end
                  RX_PARITY: begin
                     rxBadParity <= rxSync != ((^rxShift) ^ rxOddParity);
                     rxState     <= RX_STOP;
                  end
                  RX_STOP: begin
                     if (rxSync) begin
                        rxPushPulse     <= 1'b1;
                        rxPushByte      <= rxShift;
                        rxPushBadParity <= rxBadParity;
                     end else begin
                        rxFrameSet <= 1'b1;
                     end
                     rxState <= RX_IDLE;
                  end
                  default: rxState <= RX_IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_ahb_uart_fifo.sv
// Self-checking bench for ahb_uart_fifo: bus register access, loopback traffic,
// FIFO limits, parity/framing/overrun errors and reset behaviour.
module tb_ahb_uart_fifo;
   localparam logic [31:0] A_RXDATA = 32'h00, A_TXDATA = 32'h04, A_STATUS = 32'h08;
   localparam logic [31:0] A_CONTRL = 32'h0C, A_BAUD = 32'h10, A_LEVEL = 32'h14;

   logic        HCLK = 1'b0;
   logic        HRESET, HSEL, HREADY, HWRITE;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HREADYOUT, serialRx, serialTx, uart_IRQ;
   logic        loopback, rxLine;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   assign serialRx = loopback ? serialTx : rxLine;

   ahb_uart_fifo #(.FIFO_DEPTH(16), .DIV_RESET(16'd26)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADYOUT(HREADYOUT), .serialRx(serialRx), .serialTx(serialTx), .uart_IRQ(uart_IRQ)
   );

   // 10 ns bus clock with a free-running cycle counter used for latency and budgets.
   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   // One complete AHB transfer: address phase, then a data phase whose read data
   // is sampled mid-cycle; returns just after the edge that ends the data phase.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata);
      @(negedge HCLK);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata;
      rdata = HRDATA;
      @(posedge HCLK); #1;
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] unusedRead;
      applyStimulus(1'b1, addr, data, unusedRead);
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
      applyStimulus(1'b0, addr, 32'd0, data);
   endtask

   // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
   function automatic logic parityFor(input logic [7:0] d, input logic odd);
      return (($countones(d) % 2) == 1) ^ odd;
   endfunction

   // Drives one frame on serialRx at 16 cycles per bit (BAUDDIV = 0), then idles.
   task automatic driveFrame(input logic [7:0] d, input logic withParity, input logic parityBit,
                             input logic stopBit);
      @(negedge HCLK);
      rxLine = 1'b0;
      repeat (16) @(negedge HCLK);
      for (int i = 0; i < 8; i++) begin
         rxLine = d[i];
         repeat (16) @(negedge HCLK);
      end
      if (withParity) begin
         rxLine = parityBit;
         repeat (16) @(negedge HCLK);
      end
      rxLine = stopBit;
      repeat (16) @(negedge HCLK);
      rxLine = 1'b1;
      repeat (24) @(negedge HCLK);
   endtask

   // Polls STATUS until RX not-empty or the cycle budget runs out.
   task automatic waitRxReady(input int budget, output logic ok);
      logic [31:0] s;
      int start;
      start = cyc;
      ok = 1'b0;
      while (!ok && (cyc - start) < budget) begin
         busRead(A_STATUS, s);
         ok = s[3];
      end
   endtask

   task automatic test_reset;
      logic [31:0] r;
      HRESET = 1'b1;
      repeat (3) @(posedge HCLK);
      #1;
      total++; if (serialTx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx got=%b want=1", serialTx); end
      total++; if (HREADYOUT !== 1'b1) begin bad++; $display("[TB] FAIL reset_hreadyout got=%b want=1", HREADYOUT); end
      total++; if (HRDATA !== 32'd0) begin bad++; $display("[TB] FAIL reset_hrdata got=%h want=0", HRDATA); end
      total++; if (uart_IRQ !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b want=0", uart_IRQ); end
      @(negedge HCLK);
      HRESET = 1'b0;
      busRead(A_STATUS, r);
      total++; if (r !== 32'h02) begin bad++; $display("[TB] FAIL reset_status got=%h want=%h", r, 32'h02); end
      busRead(A_CONTRL, r);
      total++; if (r !== 32'h00) begin bad++; $display("[TB] FAIL reset_contrl got=%h want=0", r); end
      busRead(A_BAUD, r);
      total++; if (r !== 32'd26) begin bad++; $display("[TB] FAIL reset_bauddiv got=%0d want=26", r); end
      busRead(A_LEVEL, r);
      total++; if (r !== 32'd0) begin bad++; $display("[TB] FAIL reset_level got=%h want=0", r); end
      busRead(A_RXDATA, r);
      total++; if (r !== 32'd0) begin bad++; $display("[TB] FAIL empty_rxdata got=%h want=0", r); end
   endtask

   task automatic test_loopback;
      logic [31:0] r;
      int pushCyc, lat;
      loopback = 1'b1;
      busWrite(A_BAUD, 32'd0);
      busWrite(A_CONTRL, 32'h0C);
      busWrite(A_TXDATA, 32'h12345678);
      pushCyc = cyc;
      repeat (2) @(posedge HCLK);
      #1;
      total++; if (serialTx !== 1'b0) begin bad++; $display("[TB] FAIL tx_start_bit got=%b want=0", serialTx); end
      busRead(A_TXDATA, r);
      total++; if (r !== 32'h78) begin bad++; $display("[TB] FAIL txdata_readback got=%h want=78", r); end
      while (!uart_IRQ && (cyc - pushCyc) < 400) begin
         @(posedge HCLK); #1;
      end
      lat = cyc - pushCyc;
      total++; if (!(lat >= 140 && lat <= 200)) begin bad++; $display("[TB] FAIL irq_latency got=%0d want=140..200", lat); end
      busRead(A_STATUS, r);
      total++; if (r !== 32'h0A) begin bad++; $display("[TB] FAIL loop_status got=%h want=0a", r); end
      busRead(A_RXDATA, r);
      total++; if (r !== 32'h78) begin bad++; $display("[TB] FAIL loop_rxdata got=%h want=78", r); end
      busRead(A_STATUS, r);
      total++; if (r !== 32'h02) begin bad++; $display("[TB] FAIL loop_status_after got=%h want=02", r); end
      @(posedge HCLK); #1;
      total++; if (uart_IRQ !== 1'b0) begin bad++; $display("[TB] FAIL loop_irq_fall got=%b want=0", uart_IRQ); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r;
      int start, recv;
      loopback = 1'b1;
      busWrite(A_CONTRL, 32'h00);
      for (int i = 0; i < 20; i++) begin
         @(negedge HCLK);
         HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_TXDATA; HWRITE = 1'b1;
         if (i > 0) HWDATA = 32'(20 + i - 1);
      end
      @(negedge HCLK);
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'd39;
      @(posedge HCLK); #1;
      busRead(A_STATUS, r);
      total++; if (r[0] !== 1'b1) begin bad++; $display("[TB] FAIL burst_txfull got=%b want=1", r[0]); end
      total++; if (r[7] !== 1'b1) begin bad++; $display("[TB] FAIL burst_txovf got=%b want=1", r[7]); end
      busRead(A_LEVEL, r);
      total++; if (r[7:0] !== 8'd16) begin bad++; $display("[TB] FAIL burst_level got=%0d want=16", r[7:0]); end
      busRead(A_TXDATA, r);
      total++; if (r !== 32'd39) begin bad++; $display("[TB] FAIL burst_txlast got=%0d want=39", r); end
      start = cyc;
      recv = 0;
      while ((cyc - start) < 3300) begin
         busRead(A_STATUS, r);
         if (r[3]) begin
            busRead(A_RXDATA, r);
            total++; if (r !== 32'(20 + recv)) begin bad++; $display("[TB] FAIL burst_order got=%0d want=%0d", r, 20 + recv); end
            recv++;
         end
      end
      total++; if (!(recv >= 16 && recv <= 17)) begin bad++; $display("[TB] FAIL burst_count got=%0d want=16..17", recv); end
      busRead(A_STATUS, r);
      total++; if (r !== 32'h82) begin bad++; $display("[TB] FAIL burst_status got=%h want=82", r); end
      busWrite(A_STATUS, 32'h80);
      busRead(A_STATUS, r);
      total++; if (r !== 32'h02) begin bad++; $display("[TB] FAIL txovf_clear got=%h want=02", r); end
   endtask

   task automatic test_parity;
      logic [31:0] r;
      logic [7:0]  d;
      logic        ok;
      loopback = 1'b1;
      busWrite(A_CONTRL, 32'h20);
      busWrite(A_TXDATA, 32'hA5);
      waitRxReady(400, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL parity_loop_timeout got=%b want=1", ok); end
      busRead(A_RXDATA, r);
      total++; if (r !== 32'hA5) begin bad++; $display("[TB] FAIL parity_loop_data got=%h want=a5", r); end
      busRead(A_STATUS, r);
      total++; if (r[5] !== 1'b0) begin bad++; $display("[TB] FAIL parity_loop_err got=%b want=0", r[5]); end
      loopback = 1'b0;
      d = 8'($urandom_range(0, 255));
      driveFrame(d, 1'b1, ~parityFor(d, 1'b0), 1'b1);
      busRead(A_STATUS, r);
      total++; if (r !== 32'h2A) begin bad++; $display("[TB] FAIL parity_bad_status got=%h want=2a", r); end
      busRead(A_RXDATA, r);
      total++; if (r !== {24'd0, d}) begin bad++; $display("[TB] FAIL parity_bad_data got=%h want=%h", r, d); end
      busWrite(A_STATUS, 32'h20);
      busRead(A_STATUS, r);
      total++; if (r !== 32'h02) begin bad++; $display("[TB] FAIL parity_clear got=%h want=02", r); end
   endtask

   task automatic test_framing;
      logic [31:0] r;
      loopback = 1'b0;
      busWrite(A_CONTRL, 32'h00);
      driveFrame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      busRead(A_LEVEL, r);
      total++; if (r !== 32'd0) begin bad++; $display("[TB] FAIL frame_level got=%h want=0", r); end
      busRead(A_STATUS, r);
      total++; if (r !== 32'h42) begin bad++; $display("[TB] FAIL frame_status got=%h want=42", r); end
      total++; if (uart_IRQ !== 1'b0) begin bad++; $display("[TB] FAIL frame_irq_off got=%b want=0", uart_IRQ); end
      busWrite(A_CONTRL, 32'h10);
      repeat (2) @(posedge HCLK);
      #1;
      total++; if (uart_IRQ !== 1'b1) begin bad++; $display("[TB] FAIL frame_irq_on got=%b want=1", uart_IRQ); end
      busWrite(A_STATUS, 32'h40);
      repeat (2) @(posedge HCLK);
      #1;
      total++; if (uart_IRQ !== 1'b0) begin bad++; $display("[TB] FAIL frame_irq_clear got=%b want=0", uart_IRQ); end
      busWrite(A_CONTRL, 32'h00);
   endtask

   task automatic test_overrun;
      logic [31:0] r;
      logic [7:0]  d;
      logic [7:0]  model[$];
      loopback = 1'b0;
      busWrite(A_CONTRL, 32'h00);
      for (int i = 0; i < 17; i++) begin
         d = 8'($urandom_range(0, 255));
         driveFrame(d, 1'b0, 1'b0, 1'b1);
         if (model.size() < 16) model.push_back(d);
      end
      busRead(A_STATUS, r);
      total++; if (r !== 32'h1E) begin bad++; $display("[TB] FAIL overrun_status got=%h want=1e", r); end
      busRead(A_LEVEL, r);
      total++; if (r !== 32'h0010_0000) begin bad++; $display("[TB] FAIL overrun_level got=%h want=00100000", r); end
      while (model.size() > 0) begin
         d = model.pop_front();
         busRead(A_RXDATA, r);
         total++; if (r !== {24'd0, d}) begin bad++; $display("[TB] FAIL overrun_data got=%h want=%h", r, d); end
      end
      busRead(A_STATUS, r);
      total++; if (r !== 32'h12) begin bad++; $display("[TB] FAIL overrun_drained got=%h want=12", r); end
      busWrite(A_STATUS, 32'h10);
      busRead(A_STATUS, r);
      total++; if (r !== 32'h02) begin bad++; $display("[TB] FAIL overrun_clear got=%h want=02", r); end
   endtask

   task automatic test_random_loopback;
      logic [31:0] r;
      logic [7:0]  d;
      logic [1:0]  mode;
      logic        two, ok;
      int          bits;
      loopback = 1'b1;
      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom_range(0, 255));
         mode = 2'($urandom_range(0, 3));
         two = 1'($urandom_range(0, 1));
         busWrite(A_CONTRL, {24'd0, two, mode, 5'd0});
         busWrite(A_TXDATA, {24'd0, d});
         bits = 10 + (((mode == 2'b01) || (mode == 2'b10)) ? 1 : 0) + (two ? 1 : 0);
         waitRxReady(bits * 16 + 60, ok);
         total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL rand_timeout got=%b want=1 mode=%0d", ok, mode); end
         busRead(A_RXDATA, r);
         total++; if (r !== {24'd0, d}) begin bad++; $display("[TB] FAIL rand_data got=%h want=%h mode=%0d", r, d, mode); end
         busRead(A_STATUS, r);
         total++; if (r !== 32'h02) begin bad++; $display("[TB] FAIL rand_status got=%h want=02 mode=%0d", r, mode); end
      end
      repeat (40) @(posedge HCLK);
   endtask

   task automatic test_reset_midframe;
      logic [31:0] r;
      loopback = 1'b1;
      busWrite(A_CONTRL, 32'h02);
      busWrite(A_TXDATA, 32'h00);
      repeat (50) @(posedge HCLK);
      #1;
      total++; if (serialTx !== 1'b0) begin bad++; $display("[TB] FAIL midframe_tx got=%b want=0", serialTx); end
      total++; if (uart_IRQ !== 1'b1) begin bad++; $display("[TB] FAIL midframe_irq got=%b want=1", uart_IRQ); end
      @(negedge HCLK);
      HRESET = 1'b1;
      #1;
      total++; if (serialTx !== 1'b1) begin bad++; $display("[TB] FAIL abort_tx got=%b want=1", serialTx); end
      total++; if (uart_IRQ !== 1'b0) begin bad++; $display("[TB] FAIL abort_irq got=%b want=0", uart_IRQ); end
      total++; if (HRDATA !== 32'd0) begin bad++; $display("[TB] FAIL abort_hrdata got=%h want=0", HRDATA); end
      @(negedge HCLK);
      HRESET = 1'b0;
      busRead(A_STATUS, r);
      total++; if (r !== 32'h02) begin bad++; $display("[TB] FAIL abort_status got=%h want=02", r); end
      busRead(A_LEVEL, r);
      total++; if (r !== 32'd0) begin bad++; $display("[TB] FAIL abort_level got=%h want=0", r); end
      busRead(A_BAUD, r);
      total++; if (r !== 32'd26) begin bad++; $display("[TB] FAIL abort_bauddiv got=%0d want=26", r); end
      total++; if (serialTx !== 1'b1) begin bad++; $display("[TB] FAIL abort_tx_idle got=%b want=1", serialTx); end
   endtask

   // Hard stop in case a scenario never returns.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
      HADDR = '0; HWDATA = '0; HTRANS = 2'b00;
      loopback = 1'b0; rxLine = 1'b1;
      $display("[TB] starting ahb_uart_fifo bench");
      test_reset;
      test_loopback;
      test_back_to_back;
      test_parity;
      test_framing;
      test_overrun;
      test_random_loopback;
      test_reset_midframe;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
